// File: rtl/calc_display_pkg.sv
// Shared types and glyph helpers for the seven-segment display driver.
// Glyphs are active-low, bit0=a .. bit6=g.
package calc_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } state_e;

  localparam logic [6:0] GLYPH_BLANK = 7'h7F;
  localparam logic [6:0] GLYPH_MINUS = 7'h3F;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/calc_display_driver_bcd.sv
// Sequential double-dabble: 16-bit binary to 5 BCD digits in 16 shifts.
// done is high during the cycle whose edge performs the final shift.
module bin16_to_bcd (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        done,
  output logic [19:0] bcd
);

  logic [35:0] sh_q;
  logic [35:0] adj;
  logic [35:0] sh_d;
  logic [3:0]  cnt_q;
  logic        run_q;

  always_comb begin
    adj = sh_q;
    for (int i = 0; i < 5; i++) begin
      if (sh_q[16+4*i +: 4] >= 4'd5)
        adj[16+4*i +: 4] = sh_q[16+4*i +: 4] + 4'd3;
    end
  end

  assign sh_d = {adj[34:0], 1'b0};

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      sh_q  <= {20'd0, bin};
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      sh_q  <= sh_d;
      cnt_q <= cnt_q + 4'd1;
      if (cnt_q == 4'd15)
        run_q <= 1'b0;
    end
  end

  assign done = run_q && (cnt_q == 4'd15);
  assign bcd  = sh_q[35:16];

endmodule

// File: rtl/calc_display_driver.sv
// Renders the calculator result on an 8-digit multiplexed display,
// in hex or (un)signed decimal, converting only when the input changes.
module calc_display_driver
  import calc_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100_000,
  parameter int N_DIGITS    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        dec_mode,
  input  logic        signed_mode,
  output logic [6:0]  segments,
  output logic        dp,
  output logic [7:0]  anodes,
  output logic        busy
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REF_LAST = CW'(REFRESH_DIV - 1);

  state_e      state_q, state_d;
  logic [15:0] val_q, lval_q, mag;
  logic        dec_q, sgn_q, ldec_q, lsgn_q;
  logic        pend_q, neg_q, neg_d, changed;
  logic        bcd_start, bcd_done, seen;
  logic [19:0] bcd;
  logic [6:0]  dig_q [N_DIGITS];
  logic [6:0]  dig_d [N_DIGITS];
  logic [CW-1:0] ref_q;
  logic [2:0]  idx_q;
  logic [6:0]  seg_q;
  logic [7:0]  an_q;

  assign neg_d = sgn_q & dec_q & val_q[15];
  assign mag   = neg_d ? (~val_q + 16'd1) : val_q;
  assign changed = {val_q, dec_q, sgn_q} != {lval_q, ldec_q, lsgn_q};
  assign bcd_start = (state_q == LOAD) && dec_q;

  bin16_to_bcd u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (bcd_start),
    .bin   (mag),
    .done  (bcd_done),
    .bcd   (bcd)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (pend_q || changed) state_d = LOAD;
      LOAD:  state_d = dec_q ? SHIFT : DONE;
      SHIFT: if (bcd_done) state_d = DONE;
      DONE:  state_d = IDLE;
    endcase
  end

  // Leading-zero blanking walks down from the top BCD digit.
  always_comb begin
    seen = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) dig_d[i] = GLYPH_BLANK;
    if (ldec_q) begin
      for (int i = 4; i >= 1; i--) begin
        seen = seen | (bcd[4*i +: 4] != 4'd0);
        if (seen) dig_d[i] = hex_to_seg(bcd[4*i +: 4]);
      end
      dig_d[0] = hex_to_seg(bcd[3:0]);
      if (neg_q) dig_d[5] = GLYPH_MINUS;
    end else begin
      for (int i = 0; i < 4; i++)
        dig_d[i] = hex_to_seg(lval_q[4*i +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      val_q  <= '0;
      dec_q  <= 1'b0;
      sgn_q  <= 1'b0;
      lval_q <= '0;
      ldec_q <= 1'b0;
      lsgn_q <= 1'b0;
      pend_q <= 1'b1;
      neg_q  <= 1'b0;
      for (int i = 0; i < N_DIGITS; i++) dig_q[i] <= GLYPH_BLANK;
      ref_q  <= '0;
      idx_q  <= '0;
      seg_q  <= GLYPH_BLANK;
      an_q   <= 8'hFF;
    end else begin
      val_q <= value;
      dec_q <= dec_mode;
      sgn_q <= signed_mode;
      if (state_q == LOAD) begin
        lval_q <= val_q;
        ldec_q <= dec_q;
        lsgn_q <= sgn_q;
        neg_q  <= neg_d;
        pend_q <= 1'b0;
      end
      if (state_q == DONE) begin
        for (int i = 0; i < N_DIGITS; i++) dig_q[i] <= dig_d[i];
      end
      if (ref_q == REF_LAST) begin
        ref_q <= '0;
        idx_q <= idx_q + 3'd1;
      end else begin
        ref_q <= ref_q + 1'b1;
      end
      seg_q <= dig_q[idx_q];
      an_q  <= ~(8'd1 << idx_q);
    end
  end

  assign segments = seg_q;
  assign anodes   = an_q;
  assign dp       = 1'b1;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_calc_display_driver.sv
// Bench for calc_display_driver: table vectors, corner sequences and
// random values checked against an arithmetic display model.
module tb_calc_display_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = 16'd0;
  logic        dec_mode = 1'b0;
  logic        signed_mode = 1'b0;
  logic [6:0]  segments;
  logic        dp;
  logic [7:0]  anodes;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [6:0] disp [8];
  logic [6:0] expd [8];

  typedef struct {
    logic [15:0]     v;
    logic            d;
    logic            s;
    logic [7:0][6:0] g;
  } vec_t;

  vec_t tbl [7];

  always #5 clk = ~clk;

  calc_display_driver #(.REFRESH_DIV(4), .N_DIGITS(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .dec_mode    (dec_mode),
    .signed_mode (signed_mode),
    .segments    (segments),
    .dp          (dp),
    .anodes      (anodes),
    .busy        (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] glyph(input int n);
    logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                           7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                           7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  task automatic model(input logic [15:0] v, input logic d, input logic s);
    int x, msd, p;
    int dg [5];
    for (int i = 0; i < 8; i++) expd[i] = 7'h7F;
    if (d) begin
      x = (s && v[15]) ? 65536 - int'(v) : int'(v);
      p = 1;
      msd = 0;
      for (int i = 0; i < 5; i++) begin
        dg[i] = (x / p) % 10;
        if (dg[i] != 0) msd = i;
        p = p * 10;
      end
      for (int i = 0; i <= msd; i++) expd[i] = glyph(dg[i]);
      if (s && v[15]) expd[5] = 7'h3F;
    end else begin
      for (int i = 0; i < 4; i++) expd[i] = glyph(int'((v >> (4*i)) & 16'hF));
    end
  endtask

  task automatic apply(input logic [15:0] v, input logic d, input logic s);
    value = v;
    dec_mode = d;
    signed_mode = s;
  endtask

  task automatic wait_rise();
    int k = 0;
    while (!busy && k < 6) begin
      @(negedge clk);
      k++;
    end
    chk("busy_rise", busy, 1);
  endtask

  task automatic count_high(output int n);
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic scan();
    int seen, prev, run, bad, ntr, k;
    repeat (2) @(negedge clk);
    seen = 0; prev = -1; run = 0; bad = 0; ntr = 0;
    for (int c = 0; c < 40; c++) begin
      k = -1;
      for (int j = 0; j < 8; j++)
        if (anodes == ~(8'd1 << j)) k = j;
      if (k < 0) bad++;
      else begin
        disp[k] = segments;
        seen |= (1 << k);
        if (k == prev) run++;
        else begin
          if (prev >= 0) begin
            if (k != (prev + 1) % 8) bad++;
            if (ntr >= 1 && run != 4) bad++;
            ntr++;
          end
          prev = k;
          run = 1;
        end
      end
      @(negedge clk);
    end
    chk("anode_scan", bad, 0);
    chk("digits_seen", seen, 255);
  endtask

  task automatic cmp_disp(input string nm);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_dig%0d", nm, i), disp[i], expd[i]);
  endtask

  initial begin
    int n;
    logic [15:0] pv, rv;
    logic pd, ps, rd, rs;

    tbl[0] = '{16'd10,    1'b1, 1'b0, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h79,7'h40}};
    tbl[1] = '{16'hFFF6,  1'b1, 1'b1, {7'h7F,7'h7F,7'h3F,7'h7F,7'h7F,7'h7F,7'h79,7'h40}};
    tbl[2] = '{16'h8000,  1'b1, 1'b1, {7'h7F,7'h7F,7'h3F,7'h30,7'h24,7'h78,7'h02,7'h00}};
    tbl[3] = '{16'h8000,  1'b1, 1'b0, {7'h7F,7'h7F,7'h7F,7'h30,7'h24,7'h78,7'h02,7'h00}};
    tbl[4] = '{16'hBEEF,  1'b0, 1'b0, {7'h7F,7'h7F,7'h7F,7'h7F,7'h03,7'h06,7'h06,7'h0E}};
    tbl[5] = '{16'd0,     1'b1, 1'b0, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h40}};
    tbl[6] = '{16'd12345, 1'b1, 1'b0, {7'h7F,7'h7F,7'h7F,7'h79,7'h24,7'h30,7'h19,7'h12}};

    repeat (3) @(negedge clk);
    chk("rst_segments", segments, 7'h7F);
    chk("rst_anodes", anodes, 8'hFF);
    chk("rst_dp", dp, 1);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_anodes", anodes, 8'hFE);
    chk("post_rst_busy", busy, 1);
    count_high(n);
    chk("busy_len_init", n, 2);
    scan();
    model(16'd0, 1'b0, 1'b0);
    cmp_disp("init");

    for (int t = 0; t < 7; t++) begin
      apply(tbl[t].v, tbl[t].d, tbl[t].s);
      wait_rise();
      count_high(n);
      chk($sformatf("busy_len_t%0d", t), n, tbl[t].d ? 18 : 2);
      scan();
      for (int i = 0; i < 8; i++) expd[i] = tbl[t].g[i];
      cmp_disp($sformatf("tbl%0d", t));
    end

    // Input change during SHIFT must not abort the running conversion.
    apply(16'd10, 1'b1, 1'b0);
    wait_rise();
    n = 0;
    repeat (5) begin
      @(negedge clk);
      n++;
    end
    value = 16'd5;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("chg_busy_first", n, 18);
    n = 0;
    while (!busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("chg_busy_gap", n, 1);
    count_high(n);
    chk("chg_busy_second", n, 18);
    scan();
    model(16'd5, 1'b1, 1'b0);
    cmp_disp("chg");

    // Reset during SHIFT, then reconversion after release.
    apply(16'd999, 1'b1, 1'b0);
    wait_rise();
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_segments", segments, 7'h7F);
    chk("midrst_anodes", anodes, 8'hFF);
    chk("midrst_busy", busy, 0);
    chk("midrst_dp", dp, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_rel_anodes", anodes, 8'hFE);
    chk("midrst_rel_busy", busy, 1);
    count_high(n);
    chk("midrst_busy_len", n, 18);
    scan();
    model(16'd999, 1'b1, 1'b0);
    cmp_disp("midrst");

    pv = 16'd999; pd = 1'b1; ps = 1'b0;
    for (int r = 0; r < 24; r++) begin
      rv = 16'($urandom);
      rd = 1'($urandom);
      rs = 1'($urandom);
      if (r % 6 == 0) rv = 16'h8000 ^ 16'($urandom_range(0, 1));
      if (rv == pv && rd == pd && rs == ps) rv[0] = ~rv[0];
      apply(rv, rd, rs);
      wait_rise();
      count_high(n);
      chk($sformatf("busy_len_r%0d", r), n, rd ? 18 : 2);
      scan();
      model(rv, rd, rs);
      cmp_disp($sformatf("rnd%0d", r));
      pv = rv; pd = rd; ps = rs;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/calc_display_driver.md
Name: calc_display_driver

Overview:
Downstream stage of the RPN calculator. Consumes the calculator's 16-bit ToDisplay result and renders it on the board's 8-digit multiplexed seven-segment display.
- Decimal mode: the value is unsigned or two's-complement signed, converted by a sequential double-dabble.
- Hex mode: the four nibbles are shown directly.
- Outputs are registered, active-low segment and anode drives.

Parameters:
REFRESH_DIV, 100_000, clock cycles each digit stays selected (1 kHz per digit at 100 MHz; benches use 4)
N_DIGITS, 8, physical digits (fixed 8; parameter documents it)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
value  in  16  result from calculator ToDisplay
dec_mode  in  1  1 = decimal, 0 = hex
signed_mode  in  1  1 = treat value as two's complement (decimal mode only)
segments  out  7  active-low, bit0=a … bit6=g
dp  out  1  decimal point, active-low; always 1 (off)
anodes  out  8  active-low digit select, bit0 = rightmost
busy  out  1  conversion in progress

Behaviour:
- Reset (sync, active-high): segments=7'h7F, anodes=8'hFF, dp=1, busy=0.
  - Digit registers are set to blank and the refresh counter and index to 0.
  - A conversion is forced on the first cycle after reset is released.
- Input sampling: value, dec_mode and signed_mode are registered every cycle. If the registered tuple differs from the last converted tuple (or a forced start is pending) while the FSM is IDLE, the FSM enters LOAD on the next edge.
- FSM states: IDLE, LOAD, SHIFT, DONE.
  - IDLE: waits for a start condition.
  - LOAD (1 cycle): latch the tuple as "last converted". Magnitude = -value if signed_mode & dec_mode & value[15], else value; 16'h8000 gives magnitude 32768 unsigned. Set neg flag. Clear BCD to 0.
  - SHIFT (16 cycles, decimal only): for each of the 5 BCD nibbles, add 3 if ≥5, then shift {bcd, mag} left by 1. A 4-bit iteration counter exits after the 16th shift.
  - Hex mode goes LOAD→DONE, skipping SHIFT.
  - DONE (1 cycle): write the 8 digit glyph registers, then return to IDLE.
- busy is high in LOAD, SHIFT and DONE.
- Latency, counted in edges from the sampling edge to the updated digit registers: decimal 18, hex 2.
- Input change mid-conversion: the current conversion is never aborted. The mismatch is detected in IDLE after DONE, so a new LOAD starts the following cycle. busy drops for exactly 1 cycle (IDLE) between the two conversions.
- Decimal digit map:
  - Digits 0–4 hold BCD; leading zeros are blanked above the most-significant nonzero digit; digit 0 is always shown.
  - Digit 5 shows '-' if neg, else blank.
  - Digits 6–7 are blank.
- Hex digit map: digits 0–3 hold nibbles 0–3 with no blanking; digits 4–7 are blank.
- Glyphs (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E, '-'=3F, blank=7F.
- Multiplexing:
  - The refresh counter counts 0..REFRESH_DIV-1; at terminal count the 3-bit digit index increments and wraps 7→0.
  - anodes = ~(1<<index); segments = glyph[index]; both are registered.
  - The first post-reset cycle shows anodes=8'hFE.
- Reset mid-conversion: takes priority over everything. Outputs return to reset values on the next edge and the conversion restarts after release.

Decomposition:
- Package calc_display_pkg holds:
  - the state enum type (IDLE, LOAD, SHIFT, DONE)
  - glyph constants (GLYPH_BLANK, GLYPH_MINUS)
  - function hex_to_seg(logic [3:0]) returning logic [6:0]
- Sub-module bin16_to_bcd: sequential double-dabble.
  - Ports: clk, reset, start, bin[15:0], done, bcd[19:0].
  - Owns the SHIFT iteration counter and the shift register.
- Top level owns the input compare, sign handling, digit map and multiplexer.

Test Plan:
1. Reset, then value=10, dec, unsigned → busy high 18 cycles. Digit0=40, digit1=79, digits2–7=7F.
2. value=16'hFFF6, dec, signed → digits1..0 = "10" (79, 40), digits2–4=7F, digit5=3F.
3. value=16'h8000, dec, signed → digits4..0 = 3,2,7,6,8 (30, 24, 78, 02, 00), digit5=3F. Same value unsigned → 32768 with digit5=7F.
4. value=16'hBEEF, hex → after 2 cycles, digits3..0 = 03, 06, 06, 0E; digits4–7=7F.
5. value 10→5 changed on the 5th SHIFT cycle → display first shows 10, busy low exactly 1 cycle, then 5 (digit0=12) 18 edges later. REFRESH_DIV=4 → anodes step FE→FD→…→7F→FE every 4 cycles.
6. reset asserted mid-SHIFT → next edge segments=7F, anodes=FF, busy=0. After release the current value is converted within 19 edges.
